field_cfg_loader: RTL
=====================

// Module: field_cfg_loader
// PURPOSE
//  Datapath stage downstream of the load-config controller. On a one-cycle i_go it writes a
//  predefined start pattern into the Game of Life field memory, one full row per write.
//  While it works it asserts o_is_loading, and the controller waits on that signal.
//  Pattern rows are generated combinationally from the latched request; no external ROM.
// PARAMETERS
//  FIELD_W  64  cells per row = write data width; must be >= 4
//  FIELD_H  32  rows in field; must be >= 4
//  ADDR_W   $clog2(FIELD_H)  row address width (derived, do not override)
// PORTS
//  clk           in   1                clock
//  rst_n         in   1                asynchronous reset, active-low
//  i_go          in   1                start pulse from controller (one cycle)
//  i_cfg         in   load_cfg_req_t   requested pattern, sampled only when i_go=1
//  i_wr_ready    in   1                field memory accepts the write this cycle
//  o_is_loading  out  1                loader busy (registered)
//  o_wr_en       out  1                row write request
//  o_wr_addr     out  ADDR_W           row index being written
//  o_wr_data     out  FIELD_W          row contents; bit c = column c; 1 = live
//  o_done        out  1                one-cycle pulse after the last row is accepted
// BEHAVIOUR
//  Reset: state=IDLE, row=0, cfg_q=NO_REQ. o_is_loading=0, o_wr_en=0, o_wr_addr=0,
//   o_wr_data=0, o_done=0.
//  FSM states: IDLE -> WRITE -> DONE -> IDLE.
//   IDLE:  i_go && i_cfg!=NO_REQ -> latch cfg_q=i_cfg, row=0, go to WRITE.
//          i_go with NO_REQ is ignored and the FSM stays in IDLE.
//   WRITE: o_wr_en=1, o_wr_addr=row, o_wr_data=pattern(cfg_q,row).
//          Write completes on the edge where o_wr_en && i_wr_ready.
//          On completion: row==FIELD_H-1 -> DONE; otherwise row+1.
//          When i_wr_ready=0, hold addr/data/wr_en stable; there is no timeout.
//   DONE:  o_done=1 for exactly one cycle, then IDLE.
//  o_is_loading = (state != IDLE).
//   It rises in the cycle directly after the i_go cycle, so the controller never sees a
//   false "load finished".
//  Latency without backpressure:
//   i_go at cycle 0; writes at cycles 1..FIELD_H; o_done at FIELD_H+1;
//   o_is_loading low from FIELD_H+2.
//  i_go while busy is ignored. cfg_q stays frozen for the whole load.
//  Patterns (all unlisted rows are 0, so every load clears the whole field):
//   CFG_1 = glider: row1=0x4, row2=0x8, row3=0xE (zero-extended to FIELD_W).
//   Any other non-NO_REQ value -> all-zero rows (field clear).
//  Row counter never wraps; it is reset to 0 on entry to WRITE.
//  Reset mid-load: immediate return to IDLE with all outputs at reset values.
//   The partially written field is left as-is; no cleanup.
// TESTING
//  1 Reset, i_go=1 with CFG_1, i_wr_ready=1 held:
//    -> o_is_loading=1 at cycle 1; 32 writes to addr 0..31; data 0x4/0x8/0xE at rows 1/2/3,
//       0 elsewhere; o_done at cycle 33; o_is_loading=0 at cycle 34.
//  2 i_go with i_cfg=NO_REQ -> no o_wr_en, o_is_loading stays 0.
//  3 Drop i_wr_ready for 5 cycles at row 2 -> addr=2 and data=0x8 held stable;
//    load ends exactly 5 cycles later than scenario 1.
//  4 Extra i_go pulse at row 10 -> ignored; write sequence and o_done timing unchanged.
//  5 Assert rst_n=0 at row 7 -> outputs return to reset values asynchronously;
//    a following i_go restarts from row 0.
//  6 Run with the FCL_controller instance: cmd pulse -> exactly one full load;
//    controller returns to DEFAULT after o_is_loading falls.

Source files
------------

// File: rtl/field_cfg_loader.sv
// field_cfg_loader: writes a predefined start pattern into the Game of Life
// field memory, one full row per write, after a one-cycle i_go pulse.
// Pattern rows are generated combinationally from the latched request.

package field_cfg_pkg;
  typedef enum logic [1:0] {
    NO_REQ = 2'd0,
    CFG_1  = 2'd1,  // glider
    CFG_2  = 2'd2,  // field clear
    CFG_3  = 2'd3   // field clear
  } load_cfg_req_t;
endpackage

module field_cfg_loader
  import field_cfg_pkg::*;
#(
  parameter  int FIELD_W = 64,
  parameter  int FIELD_H = 32,
  localparam int ADDR_W  = $clog2(FIELD_H)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_go,
  input  load_cfg_req_t      i_cfg,
  input  logic               i_wr_ready,
  output logic               o_is_loading,
  output logic               o_wr_en,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic [FIELD_W-1:0] o_wr_data,
  output logic               o_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   row, row_d;
  load_cfg_req_t       cfg_q, cfg_d;

  // Row contents for a given request; every row not listed stays zero so a
  // load always overwrites the whole field.
  function automatic logic [FIELD_W-1:0] pattern(input load_cfg_req_t cfg,
                                                 input logic [ADDR_W-1:0] r);
    logic [FIELD_W-1:0] p;
    p = '0;
    if (cfg == CFG_1) begin
      if (r == ADDR_W'(1))      p = FIELD_W'(4'h4);
      else if (r == ADDR_W'(2)) p = FIELD_W'(4'h8);
      else if (r == ADDR_W'(3)) p = FIELD_W'(4'hE);
    end
    return p;
  endfunction

  // State, row counter and latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      cfg_q <= NO_REQ;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values of the others, independent of statement order.
      state <= state_d;
      row   <= row_d;
      cfg_q <= cfg_d;
    end
  end

  // Next-state logic and Moore outputs of the loader FSM.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d   = state;
    row_d     = row;
    cfg_d     = cfg_q;
    o_wr_en   = 1'b0;
    o_wr_addr = '0;
    o_wr_data = '0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_go && i_cfg != NO_REQ) begin
          cfg_d   = i_cfg;
          row_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        o_wr_en   = 1'b1;
        o_wr_addr = row;
        o_wr_data = pattern(cfg_q, row);
        if (i_wr_ready) begin
          if (row == ADDR_W'(FIELD_H - 1)) state_d = DONE;
          else                             row_d   = row + ADDR_W'(1);
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Busy flag straight from the state register: high from the cycle after i_go.
  assign o_is_loading = (state != IDLE);

endmodule
